// File: rtl/br_puf_pkg.sv
// Shared definitions for the bistable-ring PUF evaluator: FSM encoding,
// default parameters and the counter-width helper.
package br_puf_pkg;

  localparam int DEF_N_RINGS       = 32;
  localparam int DEF_CHAL_W        = 32;
  localparam int DEF_RST_CYCLES    = 4;
  localparam int DEF_SETTLE_CYCLES = 64;
  localparam int DEF_N_EVAL        = 5;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RING_RST = 3'd1;
  localparam state_t ST_SETTLE   = 3'd2;
  localparam state_t ST_SAMPLE   = 3'd3;
  localparam state_t ST_DONE     = 3'd4;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/br_puf_eval_if.sv
// Request/response handshake plus the ring-array connections of the evaluator.
interface br_puf_eval_if
  import br_puf_pkg::*;
#(
  parameter int N_RINGS = DEF_N_RINGS,
  parameter int CHAL_W  = DEF_CHAL_W
);

  logic               req_valid;
  logic               req_ready;
  logic [CHAL_W-1:0]  challenge;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [N_RINGS-1:0] response;
  logic [N_RINGS-1:0] unstable;
  logic               busy;
  // Physical ring array side: reset and challenge out, raw ring nodes in.
  logic               ring_rst;
  logic [CHAL_W-1:0]  ring_chal;
  logic [N_RINGS-1:0] ring_phys;

  modport slave (
    input  req_valid, challenge, rsp_ready, ring_phys,
    output req_ready, rsp_valid, response, unstable, busy, ring_rst, ring_chal
  );

  modport master (
    output req_valid, challenge, rsp_ready, ring_phys,
    input  req_ready, rsp_valid, response, unstable, busy, ring_rst, ring_chal
  );

endinterface

// File: rtl/br_puf_eval_ring.sv
// Boundary cell of one bistable ring; the kept net stops synthesis from
// merging or optimising the asynchronous ring node into the sampling logic.
module br_puf_eval_ring (
  input  logic i_phys,
  output logic o_q
);

  (* keep = "true" *) logic w_q;

  assign w_q = i_phys;
  assign o_q = w_q;

endmodule

// File: rtl/br_puf_eval.sv
// Bistable-ring PUF evaluator: repeats reset/settle/sample N_EVAL times per
// challenge and majority-votes each bit, flagging bits that disagreed.
module br_puf_eval
  import br_puf_pkg::*;
#(
  parameter int N_RINGS       = DEF_N_RINGS,
  parameter int CHAL_W        = DEF_CHAL_W,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int N_EVAL        = DEF_N_EVAL
) (
  input logic          clk,
  input logic          reset_n,
  br_puf_eval_if.slave puf
);

  localparam int VOTE_W = cnt_w(N_EVAL);
  localparam int PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = cnt_w(PH_MAX);
  localparam logic [VOTE_W-1:0] EVAL_LAST = VOTE_W'(N_EVAL);
  localparam logic [VOTE_W-1:0] MAJ_THR   = VOTE_W'(N_EVAL / 2);

  state_t             r_state;
  state_t             w_state_next;
  logic [PH_W-1:0]    r_phase_cnt;
  logic [VOTE_W-1:0]  r_eval_idx;
  logic [VOTE_W-1:0]  w_eval_idx_inc;
  logic [CHAL_W-1:0]  r_chal;
  logic               r_ring_rst;
  logic [N_RINGS-1:0] w_ring_q;
  logic [N_RINGS-1:0] r_sync1;
  logic [N_RINGS-1:0] r_sync2;
  logic [N_RINGS-1:0] w_response;
  logic [N_RINGS-1:0] w_unstable;
  logic               w_accept;
  logic               w_sample;
  logic               w_done_entry;

  assign w_accept       = (r_state == ST_IDLE) && puf.req_valid;
  assign w_sample       = (r_state == ST_SAMPLE);
  assign w_eval_idx_inc = r_eval_idx + VOTE_W'(1);
  assign w_done_entry   = w_sample && (w_eval_idx_inc >= EVAL_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (puf.req_valid) w_state_next = ST_RING_RST;
      ST_RING_RST: if (r_phase_cnt == '0) w_state_next = ST_SETTLE;
      ST_SETTLE:   if (r_phase_cnt == '0) w_state_next = ST_SAMPLE;
      ST_SAMPLE:   w_state_next = w_done_entry ? ST_DONE : ST_RING_RST;
      ST_DONE:     if (puf.rsp_ready) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // The phase counter reloads on every state change, so RING_RST and SETTLE
  // always last their full length regardless of history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_phase_cnt <= '0;
      r_eval_idx  <= '0;
      r_chal      <= '0;
      r_ring_rst  <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_ring_rst <= (w_state_next == ST_RING_RST);
      if (w_state_next != r_state) begin
        if (w_state_next == ST_RING_RST)
          r_phase_cnt <= PH_W'(RST_CYCLES - 1);
        else if (w_state_next == ST_SETTLE)
          r_phase_cnt <= PH_W'(SETTLE_CYCLES - 1);
        else
          r_phase_cnt <= '0;
      end else if (r_phase_cnt != '0) begin
        r_phase_cnt <= r_phase_cnt - PH_W'(1);
      end
      if (w_accept) begin
        r_chal     <= puf.challenge;
        r_eval_idx <= '0;
      end else if (w_sample) begin
        r_eval_idx <= w_eval_idx_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_ring_q;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_RINGS; gi = gi + 1) begin : g_bit
      (* keep = "true" *) logic w_ring_bit;
      logic [VOTE_W-1:0] r_vote;
      logic [VOTE_W-1:0] w_vote_new;
      logic              r_resp_bit;
      logic              r_unst_bit;

      br_puf_eval_ring u_ring (
        .i_phys (puf.ring_phys[gi]),
        .o_q    (w_ring_bit)
      );

      assign w_ring_q[gi] = w_ring_bit;
      assign w_vote_new   = r_vote + VOTE_W'(r_sync2[gi]);

      // Result is taken from the count including the final sample.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_vote     <= '0;
          r_resp_bit <= 1'b0;
          r_unst_bit <= 1'b0;
        end else begin
          if (w_accept)
            r_vote <= '0;
          else if (w_sample)
            r_vote <= w_vote_new;
          if (w_done_entry) begin
            r_resp_bit <= (w_vote_new > MAJ_THR);
            r_unst_bit <= (w_vote_new != '0) && (w_vote_new != EVAL_LAST);
          end
        end
      end

      assign w_response[gi] = r_resp_bit;
      assign w_unstable[gi] = r_unst_bit;
    end
  endgenerate

  assign puf.req_ready = (r_state == ST_IDLE);
  assign puf.rsp_valid = (r_state == ST_DONE);
  assign puf.busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign puf.response  = w_response;
  assign puf.unstable  = w_unstable;
  assign puf.ring_rst  = r_ring_rst;
  assign puf.ring_chal = r_chal;

endmodule

// File: tb/tb_br_puf_eval.sv
// Randomised scoreboard bench for br_puf_eval: a 5-evaluation instance driven
// by a ring model, and a 1-evaluation minimal-timing instance.
`timescale 1ns/1ps
module tb_br_puf_eval;
  import br_puf_pkg::*;

  localparam int NR    = 32;
  localparam int CW    = 32;
  localparam int NE_A  = 5;
  localparam int LAT_A = NE_A * (4 + 64 + 1);
  localparam int LAT_B = 1 * (1 + 1 + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  br_puf_eval_if #(.N_RINGS(NR), .CHAL_W(CW)) ifa ();
  br_puf_eval_if #(.N_RINGS(NR), .CHAL_W(CW)) ifb ();

  br_puf_eval #(.N_RINGS(NR), .CHAL_W(CW), .RST_CYCLES(4), .SETTLE_CYCLES(64), .N_EVAL(NE_A))
    u_dut_a (.clk(clk), .reset_n(reset_n), .puf(ifa));

  br_puf_eval #(.N_RINGS(NR), .CHAL_W(CW), .RST_CYCLES(1), .SETTLE_CYCLES(1), .N_EVAL(1))
    u_dut_b (.clk(clk), .reset_n(reset_n), .puf(ifb));

  typedef struct packed {
    logic [NR-1:0] resp;
    logic [NR-1:0] unst;
    logic [31:0]   lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_to(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout, actual=no event required=event", name);
  endtask

  // Majority vote per bit over a list of settled ring patterns.
  function automatic exp_t model(input logic [NR-1:0] p[$], input int lat);
    exp_t e;
    e.lat = lat;
    for (int b = 0; b < NR; b++) begin
      int ones = 0;
      foreach (p[k]) ones += int'(p[k][b]);
      e.resp[b] = (2 * ones > p.size());
      e.unst[b] = (ones != 0) && (ones != p.size());
    end
    return e;
  endfunction

  // Ring model for instance A: each ring-reset pulse starts a new evaluation
  // whose rings settle to the next pattern in the list.
  logic [NR-1:0] pats_a [NE_A];
  int ring_k = 0;
  always @(posedge ifa.ring_rst) begin
    if (ring_k < NE_A) ifa.ring_phys = pats_a[ring_k];
    ring_k++;
  end

  // Monitor A
  int acc_a = 0, lat_a = 0;
  logic seen_a = 0, hold_bad_a = 0, chal_bad_a = 0;
  logic [NR-1:0] held_r_a, held_u_a;
  logic [CW-1:0] chal_a = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      seen_a = 1'b0;
    end else begin
      if (ifa.req_valid && ifa.req_ready) begin
        acc_a = cyc + 1;
        chal_a = ifa.challenge;
        chal_bad_a = 1'b0;
        hold_bad_a = 1'b0;
        seen_a = 1'b0;
      end
      if ((ifa.busy || ifa.rsp_valid) && ifa.ring_chal !== chal_a) chal_bad_a = 1'b1;
      if (ifa.rsp_valid) begin
        if (!seen_a) begin
          seen_a = 1'b1;
          lat_a = cyc - acc_a;
          held_r_a = ifa.response;
          held_u_a = ifa.unstable;
        end else if (ifa.response !== held_r_a || ifa.unstable !== held_u_a) begin
          hold_bad_a = 1'b1;
        end
        if (ifa.rsp_ready) begin
          if (qa.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL a_unexpected_rsp: actual=response required=none");
          end else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_response", ifa.response, e.resp);
            chk("a_unstable", ifa.unstable, e.unst);
            chk("a_latency", lat_a, e.lat);
            chk("a_ring_chal_held", chal_bad_a, 1'b0);
            chk("a_hold_stable", hold_bad_a, 1'b0);
            $display("A txn chal=%h resp=%h unst=%h lat=%0d", chal_a, ifa.response, ifa.unstable, lat_a);
          end
          seen_a = 1'b0;
        end
      end
    end
  end

  // Monitor B
  int acc_b = 0, lat_b = 0;
  logic seen_b = 0, hold_bad_b = 0;
  logic [NR-1:0] held_r_b, held_u_b;
  always @(negedge clk) begin
    if (!reset_n) begin
      seen_b = 1'b0;
    end else begin
      if (ifb.req_valid && ifb.req_ready) begin
        acc_b = cyc + 1;
        hold_bad_b = 1'b0;
        seen_b = 1'b0;
      end
      if (ifb.rsp_valid) begin
        if (!seen_b) begin
          seen_b = 1'b1;
          lat_b = cyc - acc_b;
          held_r_b = ifb.response;
          held_u_b = ifb.unstable;
        end else if (ifb.response !== held_r_b || ifb.unstable !== held_u_b) begin
          hold_bad_b = 1'b1;
        end
        if (ifb.rsp_ready) begin
          if (qb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_unexpected_rsp: actual=response required=none");
          end else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_response", ifb.response, e.resp);
            chk("b_unstable", ifb.unstable, e.unst);
            chk("b_latency", lat_b, e.lat);
            chk("b_hold_stable", hold_bad_b, 1'b0);
            $display("B txn resp=%h unst=%h lat=%0d", ifb.response, ifb.unstable, lat_b);
          end
          seen_b = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic [CW-1:0] ch, output bit ok);
    ok = 1'b0;
    ifa.challenge = ch;
    ifa.req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (ifa.req_ready) ok = 1'b1;
      tick();
    end
    ifa.req_valid = 1'b0;
    if (!ok) fail_to("a_accept");
    else begin
      tick();
      ifa.challenge = '1;
    end
  endtask

  task automatic finish_a(input int stall, input bit pulse_req);
    int w = 0;
    while (!ifa.rsp_valid && w < LAT_A + 50) begin tick(); w++; end
    if (!ifa.rsp_valid) begin fail_to("a_rsp_valid"); return; end
    for (int j = 0; j < stall; j++) begin
      if (pulse_req && j == 5) begin
        ifa.req_valid = 1'b1;
        chk("a_req_ready_in_done", ifa.req_ready, 1'b0);
      end
      tick();
      ifa.req_valid = 1'b0;
    end
    ifa.rsp_ready = 1'b1;
    tick();
    ifa.rsp_ready = 1'b0;
    chk("a_idle_after_hs", ifa.req_ready, 1'b1);
  endtask

  task automatic txn_a(input logic [CW-1:0] ch, input int stall, input bit pulse_req);
    logic [NR-1:0] p[$];
    bit ok;
    foreach (pats_a[k]) p.push_back(pats_a[k]);
    qa.push_back(model(p, LAT_A));
    ring_k = 0;
    issue_a(ch, ok);
    if (ok) finish_a(stall, pulse_req);
  endtask

  task automatic txn_b(input logic [NR-1:0] pat, input int stall);
    logic [NR-1:0] p[$];
    bit ok = 1'b0;
    int w = 0;
    p.push_back(pat);
    ifb.ring_phys = pat;
    qb.push_back(model(p, LAT_B));
    ifb.challenge = $urandom;
    ifb.req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (ifb.req_ready) ok = 1'b1;
      tick();
    end
    ifb.req_valid = 1'b0;
    if (!ok) begin fail_to("b_accept"); return; end
    while (!ifb.rsp_valid && w < 50) begin tick(); w++; end
    if (!ifb.rsp_valid) begin fail_to("b_rsp_valid"); return; end
    repeat (stall) tick();
    ifb.rsp_ready = 1'b1;
    tick();
    ifb.rsp_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    int w;
    logic [NR-1:0] base;
    ifa.req_valid = 1'b0; ifa.rsp_ready = 1'b0; ifa.challenge = '0;
    ifb.req_valid = 1'b0; ifb.rsp_ready = 1'b0; ifb.challenge = '0; ifb.ring_phys = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_a_ring_rst", ifa.ring_rst, 1'b1);
    chk("rst_a_rsp_valid", ifa.rsp_valid, 1'b0);
    chk("rst_a_ring_chal", ifa.ring_chal, '0);
    reset_n = 1'b1;
    tick();
    chk("rst_a_req_ready", ifa.req_ready, 1'b1);
    chk("rst_a_busy", ifa.busy, 1'b0);
    chk("rst_a_response", ifa.response, '0);
    chk("rst_a_unstable", ifa.unstable, '0);
    chk("rst_b_req_ready", ifb.req_ready, 1'b1);

    // Fixed settled pattern, then bit 0 alternating 1,0,1,0,1.
    foreach (pats_a[k]) pats_a[k] = 32'hA5A5_5A5A;
    txn_a(32'h1234_5678, 2, 1'b0);
    foreach (pats_a[k]) pats_a[k] = {31'h52D2_AD2D, (k % 2 == 0) ? 1'b1 : 1'b0};
    txn_a(32'h1234_5678, 0, 1'b0);

    // Long backpressure with a request pulse while DONE.
    foreach (pats_a[k]) pats_a[k] = $urandom;
    txn_a($urandom, 20, 1'b1);

    // Mostly stable rings with sparse random flips per evaluation.
    for (int t = 0; t < 5; t++) begin
      base = $urandom;
      foreach (pats_a[k]) pats_a[k] = base ^ ($urandom & $urandom & $urandom);
      txn_a($urandom, $urandom_range(0, 3), 1'b0);
    end

    // Abort during the third evaluation's settle phase.
    foreach (pats_a[k]) pats_a[k] = $urandom;
    ring_k = 0;
    issue_a($urandom, ok);
    w = 0;
    while (!(ring_k >= 3 && !ifa.ring_rst) && w < LAT_A) begin tick(); w++; end
    if (w >= LAT_A) fail_to("a_third_settle");
    repeat (10) tick();
    reset_n = 1'b0;
    tick();
    chk("abort_rsp_valid", ifa.rsp_valid, 1'b0);
    chk("abort_busy", ifa.busy, 1'b0);
    chk("abort_response", ifa.response, '0);
    chk("abort_unstable", ifa.unstable, '0);
    chk("abort_req_ready", ifa.req_ready, 1'b1);
    reset_n = 1'b1;
    tick();
    foreach (pats_a[k]) pats_a[k] = $urandom;
    txn_a($urandom, 1, 1'b0);

    // Minimal-timing single-evaluation instance.
    for (int t = 0; t < 4; t++) txn_b($urandom, $urandom_range(0, 2));

    repeat (5) tick();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: actual=still running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
